// File: rtl/spart_pkg.sv
// Shared SPART message types used by the packer and the RX message queue.
package spart_pkg;
  localparam int MSG_W = 24;
  typedef logic [MSG_W-1:0] spart_msg_t;
endpackage

// File: rtl/spart_ptr_ctr.sv
// Wrap-bit pointer counter: an index that wraps DEPTH-1 -> 0 and toggles a wrap bit.
module spart_ptr_ctr #(
  parameter int IDX_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             wrap_o
);
  logic [IDX_W:0] ptr_q, ptr_d;

  // DEPTH is a power of two, so a plain binary increment carries into the wrap bit.
  always_comb begin
    ptr_d = ptr_q;
    if (inc_i) ptr_d = ptr_q + (IDX_W+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

  assign idx_o  = ptr_q[IDX_W-1:0];
  assign wrap_o = ptr_q[IDX_W];
endmodule

// File: rtl/spart_rx_msg_queue.sv
// Show-ahead circular FIFO buffering packed SPART messages for the processor's MMIO reads.
module spart_rx_msg_queue
  import spart_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             msg_valid,
  input  logic [MSG_W-1:0] msg_data,
  input  logic             rd_en,
  input  logic             ovf_clr,
  output logic [MSG_W-1:0] rd_data,
  output logic             empty,
  output logic             full,
  output logic [CNT_W-1:0] count,
  output logic             irq,
  output logic             overflow
);
  localparam int IDX_W = $clog2(DEPTH);

  spart_msg_t       mem_q [DEPTH];
  logic [IDX_W-1:0] wr_idx, rd_idx;
  logic             wr_wrap, rd_wrap;
  logic             pop, push, drop;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;

  assign empty = (wr_idx == rd_idx) && (wr_wrap == rd_wrap);
  assign full  = (wr_idx == rd_idx) && (wr_wrap != rd_wrap);

  // A pop is always possible when full, so it frees the slot the push needs.
  assign pop  = rd_en && !empty;
  assign push = msg_valid && (!full || pop);
  assign drop = msg_valid && full && !pop;

  spart_ptr_ctr #(.IDX_W(IDX_W)) u_wr_ptr (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc_i  (push),
    .idx_o  (wr_idx),
    .wrap_o (wr_wrap)
  );

  spart_ptr_ctr #(.IDX_W(IDX_W)) u_rd_ptr (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc_i  (pop),
    .idx_o  (rd_idx),
    .wrap_o (rd_wrap)
  );

  always_ff @(posedge clk) begin
    if (rst_n && push) mem_q[wr_idx] <= msg_data;
  end

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + CNT_W'(1);
    else if (pop && !push) count_d = count_q - CNT_W'(1);
  end

  // A drop in the same cycle as a clear keeps the flag set.
  always_comb begin
    ovf_d = ovf_q;
    if (drop)         ovf_d = 1'b1;
    else if (ovf_clr) ovf_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign rd_data  = empty ? '0 : mem_q[rd_idx];
  assign count    = count_q;
  assign irq      = !empty;
  assign overflow = ovf_q;
endmodule

// File: tb/tb_spart_rx_msg_queue.sv
// Directed self-checking bench for spart_rx_msg_queue with DEPTH=8.
module tb_spart_rx_msg_queue;
  logic        clk;
  logic        rst_n;
  logic        msg_valid;
  logic [23:0] msg_data;
  logic        rd_en;
  logic        ovf_clr;
  logic [23:0] rd_data;
  logic        empty;
  logic        full;
  logic [3:0]  count;
  logic        irq;
  logic        overflow;

  int err_cnt = 0;
  int chk_cnt = 0;

  spart_rx_msg_queue #(.DEPTH(8), .CNT_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .msg_valid (msg_valid),
    .msg_data  (msg_data),
    .rd_en     (rd_en),
    .ovf_clr   (ovf_clr),
    .rd_data   (rd_data),
    .empty     (empty),
    .full      (full),
    .count     (count),
    .irq       (irq),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change #1 after the edge; outputs are sampled there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [23:0] d);
    msg_valid = 1'b1;
    msg_data  = d;
    step();
    msg_valid = 1'b0;
  endtask

  task automatic pop_chk(input string tag, input logic [23:0] exp);
    chk(tag, 32'(rd_data), 32'(exp));
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; msg_valid = 1'b0; msg_data = '0; rd_en = 1'b0; ovf_clr = 1'b0;
    step(); step();
    rst_n = 1'b1;
    repeat (5) step();
    chk("rst_empty", 32'(empty), 1);
    chk("rst_irq", 32'(irq), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_rd_data", 32'(rd_data), 0);
    chk("rst_overflow", 32'(overflow), 0);
    chk("rst_full", 32'(full), 0);

    push(24'hA1B2C3);
    chk("one_irq", 32'(irq), 1);
    chk("one_count", 32'(count), 1);
    chk("one_rd_data", 32'(rd_data), 32'hA1B2C3);
    pop_chk("one_pop_data", 24'hA1B2C3);
    chk("one_empty", 32'(empty), 1);
    chk("one_count0", 32'(count), 0);

    for (int i = 1; i <= 8; i++) push(24'(i));
    chk("fill_full", 32'(full), 1);
    chk("fill_count", 32'(count), 8);
    chk("fill_ovf0", 32'(overflow), 0);
    push(24'h000009);
    chk("drop_ovf", 32'(overflow), 1);
    chk("drop_count", 32'(count), 8);
    for (int i = 1; i <= 8; i++) pop_chk($sformatf("drain_%0d", i), 24'(i));
    chk("drain_empty", 32'(empty), 1);
    chk("drain_ovf_sticky", 32'(overflow), 1);
    ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
    chk("ovf_clr", 32'(overflow), 0);

    for (int i = 1; i <= 8; i++) push(24'h20 + 24'(i));
    ovf_clr = 1'b1;
    push(24'h000099);
    ovf_clr = 1'b0;
    chk("drop_clr_set_wins", 32'(overflow), 1);
    ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
    chk("ovf_clr2", 32'(overflow), 0);

    msg_valid = 1'b1; msg_data = 24'h0000AA; rd_en = 1'b1;
    step();
    msg_valid = 1'b0; rd_en = 1'b0;
    chk("fullrw_count", 32'(count), 8);
    chk("fullrw_full", 32'(full), 1);
    chk("fullrw_ovf", 32'(overflow), 0);
    for (int i = 2; i <= 8; i++) pop_chk($sformatf("fullrw_drain_%0d", i), 24'h20 + 24'(i));
    pop_chk("fullrw_last", 24'h0000AA);
    chk("fullrw_empty", 32'(empty), 1);

    for (int i = 0; i < 5; i++) push(24'h500 + 24'(i));
    for (int i = 0; i < 5; i++) pop_chk($sformatf("pre_wrap_%0d", i), 24'h500 + 24'(i));
    for (int i = 0; i < 6; i++) push(24'h100000 + 24'(i));
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("wrap_count_%0d", i), 32'(count), 32'(6 - i));
      pop_chk($sformatf("wrap_data_%0d", i), 24'h100000 + 24'(i));
    end
    chk("wrap_count_end", 32'(count), 0);
    chk("wrap_empty", 32'(empty), 1);

    msg_valid = 1'b1; msg_data = 24'h123456; rd_en = 1'b1;
    step();
    msg_valid = 1'b0; rd_en = 1'b0;
    chk("emptyrw_count", 32'(count), 1);
    chk("emptyrw_data", 32'(rd_data), 32'h123456);
    pop_chk("emptyrw_pop", 24'h123456);
    rd_en = 1'b1; step(); rd_en = 1'b0;
    chk("idle_pop_count", 32'(count), 0);
    chk("idle_pop_empty", 32'(empty), 1);
    chk("idle_pop_data", 32'(rd_data), 0);

    for (int i = 0; i < 3; i++) push(24'h300 + 24'(i));
    chk("prerst_count", 32'(count), 3);
    rst_n = 1'b0; msg_valid = 1'b1; msg_data = 24'h000777; ovf_clr = 1'b0;
    step();
    chk("midrst_count", 32'(count), 0);
    chk("midrst_empty", 32'(empty), 1);
    chk("midrst_irq", 32'(irq), 0);
    chk("midrst_data", 32'(rd_data), 0);
    rst_n = 1'b1; msg_valid = 1'b0;
    step();
    chk("postrst_empty", 32'(empty), 1);
    chk("postrst_count", 32'(count), 0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end
endmodule

// File: doc/spart_rx_msg_queue.md
Name: spart_rx_msg_queue

Overview:
- Buffers complete 24-bit game messages coming out of the SPART message packer (one-cycle `msg_valid` strobe plus 24-bit `msg_data`).
- Lets the board processor read messages at its own pace instead of having to catch each single-cycle strobe.
- Sits directly downstream of the packer and upstream of the processor's MMIO read logic.
- Circular FIFO with show-ahead head, level interrupt, occupancy count and sticky overflow flag.

Parameters:
- DEPTH, 8, number of message entries; power of 2, minimum 2.
- CNT_W, $clog2(DEPTH)+1, width of the occupancy count.

Ports:
- clk  input  1  system clock
- rst_n  input  1  synchronous, active-low reset
- msg_valid  input  1  one-cycle strobe: msg_data holds a complete 3-byte message
- msg_data  input  24  packed message; byte0 in [7:0], byte2 in [23:16]
- rd_en  input  1  pop the head entry this cycle
- ovf_clr  input  1  clear the sticky overflow flag
- rd_data  output  24  head entry (show-ahead)
- empty  output  1  queue holds no entries
- full  output  1  queue holds DEPTH entries
- count  output  CNT_W  number of valid entries, 0..DEPTH
- irq  output  1  level interrupt, equals !empty
- overflow  output  1  sticky: at least one message was dropped

Behaviour:
- Reset values:
  - wr_ptr = 0, rd_ptr = 0, count = 0.
  - empty = 1, full = 0, irq = 0, overflow = 0.
  - rd_data = 0; storage array contents need not be cleared.
- Pointers:
  - Width $clog2(DEPTH)+1; the MSB is the wrap bit.
  - empty = (wr_ptr == rd_ptr).
  - full = index bits equal and wrap bits differ.
  - Index bits wrap from DEPTH-1 to 0 and toggle the wrap bit.
- Write: when msg_valid=1 and (!full or a pop is accepted this cycle):
  - mem[wr_idx] <= msg_data; wr_ptr increments.
  - The entry is visible on rd_data / count the next cycle.
- Pop: when rd_en=1 and !empty, rd_ptr increments. rd_en while empty is ignored; no state changes.
- rd_data:
  - Combinational mem[rd_idx] when !empty.
  - Forced to 0 when empty.
  - No write-to-read bypass: a message written into an empty queue appears one cycle after msg_valid.
- Simultaneous events:
  - Push and pop while not empty: both occur, count unchanged.
  - Push and pop while full: pop frees a slot, the write is accepted, no overflow.
  - Push and pop while empty: the write is accepted, the pop is ignored, count becomes 1.
- Overflow:
  - msg_valid while full with no accepted pop: the message is dropped, no pointer changes, overflow <= 1 next cycle.
  - ovf_clr=1 clears overflow next cycle. If a drop and ovf_clr occur in the same cycle, set wins (overflow stays 1).
- count:
  - Registered; +1 on write only, -1 on pop only, unchanged when both or neither.
  - Must always equal wr_ptr - rd_ptr (modulo 2^CNT_W).
- msg_valid asserted on consecutive cycles: each cycle is a distinct message; the queue must accept one per cycle.
- Reset mid-operation: all queued messages are discarded, all outputs return to reset values on the next edge, and any in-flight msg_valid during reset is ignored.
- Latency: msg_valid to irq rising = 1 cycle; rd_en to next head on rd_data = 1 cycle.

Decomposition:
- Shared package spart_pkg:
  - localparam MSG_W = 24.
  - typedef logic [MSG_W-1:0] spart_msg_t, used for msg_data/rd_data here and for the packer's tx/rx message ports.
- One natural sub-module: spart_ptr_ctr, the wrap-bit pointer counter (increment enable, index and wrap outputs), instantiated twice for wr_ptr and rd_ptr.
- Storage is an inferred register array inside the top; no separate RAM module.

Test Plan:
- Reset, then idle 5 cycles -> empty=1, irq=0, count=0, rd_data=24'h000000, overflow=0.
- Single msg_valid with 24'hA1B2C3 -> next cycle irq=1, count=1, rd_data=24'hA1B2C3; rd_en one cycle -> empty=1, count=0.
- Push 8 consecutive messages 24'h000001..24'h000008 (DEPTH=8), one per cycle -> full=1, count=8; 9th push 24'h000009 -> dropped, overflow=1; pop all 8 -> order 1..8 exactly; ovf_clr -> overflow=0.
- Queue full, same cycle msg_valid 24'h0000AA and rd_en -> count stays 8, overflow stays 0, and after draining 24'h0000AA is the last entry out.
- Wrap-around: push 5, pop 5, then push 6 (values 24'h100000+i) -> pointers wrap past index 7, pops return values in order, count tracks 6..0.
- Empty queue, same cycle msg_valid 24'h123456 and rd_en -> count=1, rd_data=24'h123456; then rd_en with count=0 -> no change. Separately, assert rst_n=0 with count=3 -> next cycle count=0, empty=1, irq=0.
